// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   state_t   : FSM state encoding
//   F3_*      : funct3 access size/sign codes
//   f3_legal  : funct3 legality for a load or a store
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3, input logic st);
    if (st) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath for the load/store unit (purely combinational).
//   f3, off          : live funct3 / addr[1:0] -> misalign
//   lf3, loff, lwe   : latched funct3 / addr[1:0] / write flag
//   sdata -> wstrb, wdata : lane-replicated store data and byte enables
//   rdata -> lext         : shifted and sign/zero-extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  output logic        misalign,
  input  logic [2:0]  lf3,
  input  logic [1:0]  loff,
  input  logic        lwe,
  input  logic [31:0] sdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lext
);

  logic [31:0] lane;

  always_comb begin
    misalign = 1'b0;
    case (f3)
      F3_W:       misalign = |off;
      F3_H, F3_HU: misalign = off[0];
      default:    misalign = 1'b0;
    endcase
  end

  // Loads never assert byte enables; wdata is don't-care for them.
  always_comb begin
    wstrb = 4'b0000;
    wdata = sdata;
    if (lwe) begin
      case (lf3)
        F3_B: begin
          wstrb = 4'b0001 << loff;
          wdata = {4{sdata[7:0]}};
        end
        F3_H: begin
          wstrb = 4'b0011 << loff;
          wdata = {2{sdata[15:0]}};
        end
        default: begin
          wstrb = 4'b1111;
          wdata = sdata;
        end
      endcase
    end
  end

  always_comb begin
    lane = rdata >> {loff, 3'b000};
    case (lf3)
      F3_B:    lext = {{24{lane[7]}}, lane[7:0]};
      F3_H:    lext = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   lext = {24'd0, lane[7:0]};
      F3_HU:   lext = {16'd0, lane[15:0]};
      default: lext = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a CPU load/store into a single valid/ready memory
// request, waits for read data, and returns the extended load result.
//   clk, rst_n (sync, active-low)
//   mem_read, mem_write, funct3, ALUresult, store_data : CPU request
//   lsu_stall, load_data, misaligned, access_fault     : CPU status
//   dmem_req_* / dmem_we / dmem_addr / dmem_wdata / dmem_wstrb : request
//   dmem_rsp_valid, dmem_rdata                          : read response
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUresult,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        access_fault,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, sd_q, ld_q;
  logic [2:0]  f3_q;
  logic        we_q, fault_q;

  logic        idle, active, illegal, misal, launch;
  logic [3:0]  wstrb;
  logic [31:0] wdata, lext;

  lsu_align u_align (
    .f3(funct3), .off(ALUresult[1:0]), .misalign(misal),
    .lf3(f3_q), .loff(addr_q[1:0]), .lwe(we_q),
    .sdata(sd_q), .wstrb(wstrb), .wdata(wdata),
    .rdata(dmem_rdata), .lext(lext)
  );

  assign idle    = (state == IDLE);
  assign active  = mem_read | mem_write;
  assign illegal = active & ((mem_read & mem_write) | !f3_legal(funct3, mem_write));
  assign launch  = idle & active & !illegal & !misal;

  // Outputs forced low while rst_n is asserted, even before the reset edge.
  assign lsu_stall      = rst_n & (launch | (state == REQ) | (state == WAIT_RSP));
  assign misaligned     = rst_n & idle & active & !illegal & misal;
  assign access_fault   = rst_n & ((idle & illegal) | fault_q);
  assign dmem_req_valid = rst_n & (state == REQ);
  assign dmem_we        = rst_n & we_q;
  assign dmem_addr      = rst_n ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem_wdata     = rst_n ? wdata : 32'd0;
  assign dmem_wstrb     = rst_n ? wstrb : 4'd0;
  assign load_data      = ld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      sd_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          addr_q <= ALUresult;
          sd_q   <= store_data;
          f3_q   <= funct3;
          we_q   <= mem_write;
          cnt    <= '0;
          state  <= REQ;
        end
        // A load accepted on the last allowed cycle has no room left for its
        // response, so it times out instead of entering WAIT_RSP.
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem_req_ready && we_q) state <= DONE;
          else if (cnt == TO_LAST) begin
            fault_q <= 1'b1;
            ld_q    <= '0;
            state   <= DONE;
          end else if (dmem_req_ready) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          cnt <= cnt + 1'b1;
          if (dmem_rsp_valid) begin
            ld_q  <= lext;
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            fault_q <= 1'b1;
            ld_q    <= '0;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int T = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUresult = '0, store_data = '0;
  logic        lsu_stall, misaligned, access_fault;
  logic [31:0] load_data;
  logic        dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .ALUresult(ALUresult), .store_data(store_data),
    .lsu_stall(lsu_stall), .load_data(load_data), .misaligned(misaligned),
    .access_fault(access_fault), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} req_t;
  typedef struct packed {logic flt; logic [31:0] ld;} done_t;
  typedef struct packed {logic mis; logic flt;} err_t;

  req_t  reqq[$];
  done_t doneq[$];
  err_t  errq[$];

  int   vec = 0, errs = 0;
  logic mon_en = 1'b0, prev_stall = 1'b0;
  logic [31:0] ld_model = '0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_empty(input string nm);
    vec++;
    errs++;
    $display("FAIL %s: DUT output with no expected entry (got event, want none)", nm);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents something.
  req_t er; done_t ed; err_t ee;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (dmem_req_valid && dmem_req_ready) begin
        if (reqq.size() == 0) fail_empty("req");
        else begin
          er = reqq.pop_front();
          check("req", {dmem_we, dmem_addr, dmem_wstrb, dmem_we ? dmem_wdata : 32'd0},
                {er.we, er.addr, er.wstrb, er.we ? er.wdata : 32'd0});
        end
      end
      if (prev_stall && !lsu_stall) begin
        if (doneq.size() == 0) fail_empty("done");
        else begin
          ed = doneq.pop_front();
          check("done", {access_fault, misaligned, load_data}, {ed.flt, 1'b0, ed.ld});
        end
      end else if (misaligned || access_fault) begin
        if (errq.size() == 0) fail_empty("err");
        else begin
          ee = errq.pop_front();
          check("err", {misaligned, access_fault}, {ee.mis, ee.flt});
        end
      end
    end
    prev_stall <= lsu_stall;
  end

  // Reference: bytes [off, off+nb) of the word are the accessed ones.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input int rdl, input int sdl, input logic [31:0] rdw);
    logic illegal, mis;
    int nb, off, c_rdy, c_rsp, fin, e, sc;
    logic flt, stall_done;
    logic [3:0] ws;
    logic [31:0] wd, lane;
    longint unsigned v;
    off = int'(a[1:0]);
    nb = 1 << f3[1:0];
    illegal = (rd & wr) | (wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
    mis = (off % nb) != 0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; ALUresult = a; store_data = sd;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'($urandom % 2); dmem_rdata = $urandom;
    if (!(rd | wr)) return;
    if (illegal || mis) begin
      errq.push_back('{mis: !illegal, flt: illegal});
      #1 check("err_stall", lsu_stall, 1'b0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      ws[i] = wr && (i >= off) && (i < off + nb);
      wd[8*i +: 8] = sd[8*(i % nb) +: 8];
    end
    c_rdy = rdl + 1;
    c_rsp = rdl + sdl + 2;
    fin = wr ? c_rdy : c_rsp;
    flt = fin > T;
    e = flt ? T : fin;
    if (c_rdy <= T) reqq.push_back('{we: wr, addr: {a[31:2], 2'b00}, wstrb: ws, wdata: wd});
    if (rd) begin
      lane = rdw >> (8 * off);
      v = lane & ((64'd1 << (8 * nb)) - 1);
      if (!f3[2] && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
      ld_model = flt ? 32'd0 : v[31:0];
    end
    doneq.push_back('{flt: flt, ld: ld_model});
    #1 sc = int'(lsu_stall);
    for (int c = 1; c <= e; c++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      dmem_req_ready = (c == c_rdy);
      if (rd && c == c_rsp) dmem_rsp_valid = 1'b1;
      else dmem_rsp_valid = (c <= c_rdy) ? 1'($urandom % 2) : 1'b0;
      dmem_rdata = (rd && c == c_rsp) ? rdw : $urandom;
      #1 sc += int'(lsu_stall);
    end
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'($urandom % 2);
    #1 stall_done = lsu_stall;
    check("stall_cycles", {32'(sc), stall_done}, {32'(e + 1), 1'b0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lf3 [5];
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {dmem_req_valid, dmem_we, dmem_wstrb, misaligned, access_fault,
                        lsu_stall, dmem_addr, dmem_wdata, load_data}, '0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 0);     // SW, ready on 2nd REQ cycle
    txn(1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h80FF_FFFF);    // LB
    txn(1, 0, 3'b100, 32'h103, 0, 2, 0, 32'h80FF_FFFF);    // LBU
    txn(0, 1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 0);    // SH
    txn(1, 0, 3'b010, 32'h101, 0, 0, 0, 0);                // LW misaligned
    txn(1, 0, 3'b010, 32'h200, 0, 0, 40, 32'h1234_5678);   // LW timeout
    txn(1, 0, 3'b011, 32'h200, 0, 0, 0, 0);                // illegal load
    txn(1, 1, 3'b010, 32'h200, 0, 0, 0, 0);                // read+write
    txn(0, 1, 3'b010, 32'h300, 32'h55AA55AA, T - 1, 0, 0); // store ready on last cycle
    txn(0, 1, 3'b000, 32'h301, 32'h77, T, 0, 0);           // store timeout

    // Reset in WAIT_RSP, then a late response that must be ignored.
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; ALUresult = 32'h400;
    reqq.push_back('{we: 1'b0, addr: 32'h400, wstrb: 4'b0000, wdata: 32'd0});
    @(posedge clk); #1;
    mem_read = 1'b0; dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0; rst_n = 1'b0;
    #1 check("mid_reset_out", {dmem_req_valid, dmem_we, dmem_wstrb, misaligned, access_fault,
                               lsu_stall, dmem_addr, dmem_wdata}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    ld_model = 32'd0;
    #1 check("after_reset", {lsu_stall, dmem_req_valid}, 2'b00);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    #1 check("late_rsp_ignored", {lsu_stall, load_data}, '0);

    for (int n = 0; n < 250; n++) begin
      int k;
      logic [2:0] f3;
      logic r, w;
      k = $urandom_range(0, 9);
      r = (k <= 3) || (k == 8);
      w = (k >= 4 && k <= 8);
      f3 = ($urandom % 4 != 0) ? lf3[$urandom_range(0, 4)] : 3'($urandom);
      txn(r, w, f3, $urandom, $urandom, $urandom_range(0, 8), $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reqq_empty", 32'(reqq.size()), 0);
    check("doneq_empty", 32'(doneq.size()), 0);
    check("errq_empty", 32'(errq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles spent in REQ plus WAIT_RSP before a fault.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 mem_read  input  1  load requested by the current instruction.
REQ-005 mem_write  input  1  store requested by the current instruction.
REQ-006 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUresult  input  32  byte address computed by the ALU.
REQ-008 store_data  input  32  rs2 value to store.
REQ-009 lsu_stall  output  1  freeze PC and register-file write.
REQ-010 load_data  output  32  extended load result, valid in DONE.
REQ-011 misaligned  output  1  one-cycle pulse on a misaligned access.
REQ-012 access_fault  output  1  one-cycle pulse on illegal funct3, read+write conflict, or timeout.
REQ-013 dmem_req_valid  output  1  memory request valid.
REQ-014 dmem_req_ready  input  1  memory accepts the request.
REQ-015 dmem_we  output  1  1 = write request.
REQ-016 dmem_addr  output  32  word address; {ALUresult[31:2],2'b00}.
REQ-017 dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_wstrb  output  4  byte enables.
REQ-019 dmem_rsp_valid  input  1  read data valid.
REQ-020 dmem_rdata  input  32  read word.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT_RSP and DONE.
REQ-022 IDLE, legal aligned access: address, funct3, data and we SHALL be latched; next state REQ; lsu_stall SHALL be 1 combinationally in the same cycle.
REQ-023 Alignment SHALL be checked as follows: W needs addr[1:0]=00; H/HU needs addr[0]=0; B/BU needs nothing; a violation SHALL pulse misaligned, issue no request, keep lsu_stall=0 and stay in IDLE.
REQ-024 Illegal funct3 (loads 011/110/111, stores >=011) or mem_read&mem_write both 1 SHALL pulse access_fault, issue no request and stay in IDLE.
REQ-025 REQ: dmem_req_valid=1 with addr/we/wdata/wstrb held stable until dmem_req_ready; on ready, a store SHALL go to DONE and a load SHALL go to WAIT_RSP.
REQ-026 WAIT_RSP: on dmem_rsp_valid the extended data SHALL be registered into load_data; next state DONE.
REQ-027 DONE: lsu_stall=0 and no new launch; next state IDLE unconditionally, so a held mem_read/mem_write is not relaunched.
REQ-028 Stores: SB wstrb=0001<<addr[1:0] with wdata={4{sd[7:0]}}; SH wstrb=0011<<addr[1:0] with wdata={2{sd[15:0]}}; SW wstrb=1111 with wdata=sd; loads SHALL use wstrb=0000.
REQ-029 Loads: lane = dmem_rdata >> (8*addr[1:0]); B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-030 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT_RSP; at TIMEOUT_CYCLES it SHALL pulse access_fault, set load_data=0 and go to DONE.
REQ-031 dmem_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-032 lsu_stall SHALL be 1 in REQ and WAIT_RSP, and 0 in DONE and in idle IDLE.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, clear the counter, and zero load_data and all latched fields, from any state including mid-request.
REQ-034 During reset, all outputs SHALL be 0: dmem_req_valid, dmem_we, dmem_wstrb, misaligned, access_fault, lsu_stall, dmem_addr, dmem_wdata.

Structure
REQ-035 Package lsu_pkg SHALL hold the FSM state encoding and the funct3 size constants.
REQ-036 Combinational sub-module lsu_align SHALL compute wstrb, wdata, the misalign flag and load extension; the FSM and counter stay in load_store_unit.

Verification
REQ-037 Scenario: SW addr 0x100, data 0xDEADBEEF, ready after 2 cycles -> wstrb 1111, dmem_addr 0x100, stall for 3 cycles, DONE, no fault.
REQ-038 Scenario: LB addr 0x103, rdata 0x80FF_FFFF -> load_data 0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-039 Scenario: SH addr 0x102, data 0x0000_1234 -> wstrb 1100, wdata 0x12341234.
REQ-040 Scenario: LW addr 0x101 -> misaligned pulse 1 cycle, dmem_req_valid never 1, lsu_stall 0.
REQ-041 Scenario: LW with dmem_rsp_valid never asserted, TIMEOUT_CYCLES=8 -> access_fault pulse on count 8, load_data 0, IDLE after DONE.
REQ-042 Scenario: rst_n low for one cycle during WAIT_RSP, then a late rsp_valid -> IDLE, all outputs 0, late response ignored.
